// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  localparam int REG_W_DEF  = 4;
  localparam int MC_LAT_DEF = 4;
  localparam int PERF_W     = 16;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter used for the optional performance counters.
module sat_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int W = PERF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, sticking at all-ones once reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline hazard controller: stalls, flushes and multi-cycle EX sequencing.
// Optional macro PIPE_PERF_COUNTERS_EN adds stall_cnt / flush_cnt outputs.
//
// state   | meaning
// RUN     | normal issue; branch / load-use hazards handled here
// MC_WAIT | multi-cycle op holds EX; front end frozen, bubbles into MEM
module pipeline_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W  = REG_W_DEF,
  parameter int MC_LAT = MC_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_mc_start,
  input  logic             mem_wait,
  output logic             en_if,
  output logic             en_id,
  output logic             en_ex,
  output logic             en_mem,
  output logic             en_wb,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_mem,
  output logic             busy
`ifdef PIPE_PERF_COUNTERS_EN
  ,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  // The start cycle itself is one EX cycle and the cnt==0 cycle is the last,
  // so MC_LAT-2 loaded here gives MC_LAT cycles of EX occupancy.
  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 2);

  state_t     state, state_nxt;
  logic [3:0] mc_cnt, mc_cnt_nxt;
  logic       load_use;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // State and countdown registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      mc_cnt <= 4'd0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
    end
  end

  // Next-state logic; a memory wait freezes everything.
  always_comb begin
    state_nxt  = state;
    mc_cnt_nxt = mc_cnt;
    if (!mem_wait) begin
      unique case (state)
        RUN: begin
          if (ex_mc_start) begin
            state_nxt  = MC_WAIT;
            mc_cnt_nxt = MC_LOAD;
          end
        end
        MC_WAIT: begin
          if (mc_cnt == 4'd0) begin
            state_nxt = RUN;
          end else begin
            mc_cnt_nxt = mc_cnt - 4'd1;
          end
        end
        default: begin
          state_nxt  = RUN;
          mc_cnt_nxt = 4'd0;
        end
      endcase
    end
  end

  // Enables and flushes by priority: mem_wait, multi-cycle, branch, load-use.
  always_comb begin
    en_if     = 1'b1;
    en_id     = 1'b1;
    en_ex     = 1'b1;
    en_mem    = 1'b1;
    en_wb     = 1'b1;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    busy      = (state == MC_WAIT);
    if (mem_wait) begin
      en_if  = 1'b0;
      en_id  = 1'b0;
      en_ex  = 1'b0;
      en_mem = 1'b0;
      en_wb  = 1'b0;
    end else if (state == MC_WAIT) begin
      en_if     = 1'b0;
      en_id     = 1'b0;
      en_ex     = 1'b0;
      flush_mem = 1'b1;
    end else if (ex_mc_start) begin
      // Op enters EX normally; a coincident branch is ignored.
    end else if (ex_branch_taken) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (load_use) begin
      en_if    = 1'b0;
      en_id    = 1'b0;
      flush_ex = 1'b1;
    end
  end

`ifdef PIPE_PERF_COUNTERS_EN
  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!en_if),
    .count (stall_cnt)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_id | flush_ex),
    .count (flush_cnt)
  );
`endif

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter REG_W, default 4: register-address width.
REQ-002 Parameter MC_LAT, default 4, legal range 2..15: total EX-occupancy cycles of a multi-cycle op.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low; asserting it clears all state immediately, independent of clk.
REQ-005 id_rs1, id_rs2  in  REG_W  source registers of the instruction in ID.
REQ-006 ex_rd  in  REG_W  destination register of the instruction in EX.
REQ-007 ex_mem_read  in  1  instruction in EX is a load.
REQ-008 ex_branch_taken  in  1  taken branch or jump resolved in EX.
REQ-009 ex_mc_start  in  1  multi-cycle op entering EX; one-cycle pulse.
REQ-010 mem_wait  in  1  data memory not ready.
REQ-011 en_if, en_id, en_ex, en_mem, en_wb  out  1 each  enables for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
REQ-012 flush_id, flush_ex, flush_mem  out  1 each  select a zero bubble at the IF/ID, ID/EX and EX/MEM register inputs.
REQ-013 busy  out  1  high while in MC_WAIT.

Function
REQ-014 States: RUN and MC_WAIT. Countdown counter mc_cnt is 4 bits wide.
REQ-015 Idle outputs (RUN, no hazard): all en_* = 1, all flush_* = 0, busy = 0.
REQ-016 Outputs are combinational from state and inputs. Zero latency: a hazard detected in cycle N acts on the clock edge that ends cycle N.
REQ-017 Priority, highest first: mem_wait, MC_WAIT / ex_mc_start, ex_branch_taken, load-use.
REQ-018 mem_wait = 1, in any state: all en_* = 0, all flush_* = 0, and mc_cnt holds.
REQ-019 RUN with ex_mc_start = 1: load mc_cnt = MC_LAT-2 and go to MC_WAIT. Enables stay as in idle this cycle.
REQ-020 MC_WAIT outputs: en_if, en_id, en_ex = 0; en_mem, en_wb = 1; flush_mem = 1; busy = 1.
REQ-021 MC_WAIT transitions: if mc_cnt = 0, go to RUN; otherwise decrement mc_cnt. The op therefore occupies EX for exactly MC_LAT cycles.
REQ-022 Branch in RUN (ex_branch_taken = 1): flush_id = 1 and flush_ex = 1 for one cycle; all en_* = 1.
REQ-023 Load-use is detected when: ex_mem_read = 1, ex_rd != 0, and ex_rd equals id_rs1 or id_rs2.
REQ-024 Load-use response: en_if = 0, en_id = 0, flush_ex = 1 for one cycle; other enables = 1.
REQ-025 Branch and load-use in the same cycle: the branch response applies and the load-use stall is dropped.
REQ-026 ex_mc_start and ex_branch_taken in the same cycle is illegal. The controller honours ex_mc_start and ignores the branch.
REQ-027 ex_mc_start asserted during MC_WAIT is ignored.

Reset
REQ-028 When reset = 0: state = RUN, mc_cnt = 0, performance counters = 0. Outputs then follow REQ-015/018.
REQ-029 Reset during MC_WAIT aborts the op: next state RUN, busy = 0 immediately.

Configuration
REQ-030 Macro PIPE_PERF_COUNTERS_EN, when defined, adds two outputs:
- stall_cnt  out  16: increments every cycle en_if = 0.
- flush_cnt  out  16: increments every cycle (flush_id | flush_ex) = 1.
Both saturate at 16'hFFFF and reset to 0.
REQ-031 Macro not defined: both ports and their logic are absent, and all other behaviour is identical.

Structure
REQ-032 Package pipeline_ctrl_pkg holds: the state enum (RUN, MC_WAIT), REG_W_DEF = 4, MC_LAT_DEF = 4, PERF_W = 16.
REQ-033 Sub-module sat_counter: PERF_W-bit saturating counter with increment input and async active-low reset. It is instantiated twice, only under PIPE_PERF_COUNTERS_EN.

Verification
REQ-034 Load-use: ex_mem_read = 1, ex_rd = 3, id_rs2 = 3 -> en_if = 0, en_id = 0, flush_ex = 1 for one cycle; with ex_rd = 0 -> no stall.
REQ-035 Branch and load-use together: ex_branch_taken = 1 with the REQ-034 hazard -> flush_id = 1, flush_ex = 1, all en_* = 1.
REQ-036 Multi-cycle, MC_LAT = 4: ex_mc_start pulse -> busy = 1 for 3 cycles with en_ex = 0 and flush_mem = 1, then RUN.
REQ-037 Multi-cycle with memory wait: mem_wait = 1 for 2 cycles inside MC_WAIT -> all en_* = 0, and busy is extended to 5 cycles total.
REQ-038 Reset mid-op: reset low during MC_WAIT, asserted between clock edges -> busy = 0 asynchronously; after release, idle outputs per REQ-015.
REQ-039 Counters (macro defined): 70000 forced stall cycles -> stall_cnt = 16'hFFFF and holds there.
